// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: opcodes, instruction kinds and FSM state shared by the encoder and control decode.
package instr_encoder_pkg;
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   typedef enum logic [2:0] {
      K_R      = 3'd0,
      K_IMM    = 3'd1,
      K_LOAD   = 3'd2,
      K_STORE  = 3'd3,
      K_BRANCH = 3'd4
   } kind_e;
   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_e;
endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack: packs kind and register/immediate fields into a 32-bit instruction word.
module instr_field_pack
   import instr_encoder_pkg::*;
(
   input  logic [2:0]  kind,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [12:0] imm,
   output logic [31:0] word,
   output logic        illegal
);
   always_comb begin
      word = kind == K_R      ? {funct7, rs2, rs1, funct3, rd, OPC_R} :
             kind == K_IMM    ? {imm[11:0], rs1, funct3, rd, OPC_IMM} :
             kind == K_LOAD   ? {imm[11:0], rs1, funct3, rd, OPC_LOAD} :
             kind == K_STORE  ? {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE} :
             kind == K_BRANCH ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH} :
                                32'h0;
      // branch targets must be halfword aligned
      illegal = kind > K_BRANCH || (kind == K_BRANCH && imm[0]);
   end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes requests into instruction words and writes them to sequential memory addresses.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        Clear_i,
   input  logic        Req_valid_i,
   output logic        Req_ready_o,
   input  logic [2:0]  Kind_i,
   input  logic [2:0]  Funct3_i,
   input  logic [6:0]  Funct7_i,
   input  logic [4:0]  Rd_i,
   input  logic [4:0]  Rs1_i,
   input  logic [4:0]  Rs2_i,
   input  logic [12:0] Imm_i,
   output logic        Wr_valid_o,
   input  logic        Wr_ready_i,
   output logic [31:0] Instr_o,
   output logic [31:0] Addr_o,
   output logic [8:0]  Count_o,
   output logic        Full_o,
   output logic        Err_o
);
   state_e      state, state_nxt;
   logic [31:0] word;
   logic        illegal;
   logic        clr_pend;
   logic        accept;
   logic        done;
   logic        clr_now;
   instr_field_pack u_pack (
      .kind    (Kind_i),
      .funct3  (Funct3_i),
      .funct7  (Funct7_i),
      .rd      (Rd_i),
      .rs1     (Rs1_i),
      .rs2     (Rs2_i),
      .imm     (Imm_i),
      .word    (word),
      .illegal (illegal)
   );
   assign accept  = Req_valid_i && Req_ready_o;
   assign done    = state == WRITE && Wr_ready_i;
   assign clr_now = clr_pend || Clear_i;
   assign Full_o  = Count_o == 9'(DEPTH);
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nxt;
   end
   always_comb begin
      state_nxt = state == IDLE ? ((accept && !illegal) ? WRITE : IDLE) :
                                  (Wr_ready_i ? IDLE : WRITE);
   end
   always_comb begin
      Wr_valid_o  = state == WRITE;
      Req_ready_o = state == IDLE && !Full_o && !Clear_i;
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         Instr_o  <= '0;
         Addr_o   <= BASE_ADDR;
         Count_o  <= '0;
         Err_o    <= 1'b0;
         clr_pend <= 1'b0;
      end else begin
         if (accept && !illegal) begin
            Instr_o <= word;
            Addr_o  <= BASE_ADDR + {21'b0, Count_o, 2'b00};
         end
         if (accept && illegal) Err_o <= 1'b1;
         if (state == IDLE && Clear_i) begin
            Count_o <= '0;
            Err_o   <= 1'b0;
         end
         // a clear seen mid-write is held until the write retires, which then goes uncounted
         if (state == WRITE && Clear_i) clr_pend <= 1'b1;
         if (done) begin
            Count_o  <= clr_now ? 9'd0 : Count_o + 9'd1;
            Err_o    <= clr_now ? 1'b0 : Err_o;
            clr_pend <= 1'b0;
         end
      end
   end
endmodule
